// File: rtl/phase_window_stats_pkg.sv
// Shared phase constants and FSM encoding for the phase window statistics block.
package phase_window_stats_pkg;

    // Phase words are signed 0.1 degree units.
    localparam int PHASE_W    = 16;
    localparam int PHASE_HALF = 1800;
    localparam int PHASE_FULL = 3600;

    // Width for sums of two phases (|x| <= 3600) before folding back.
    localparam int WRAP_W = 17;

    // Width of the window sample counter (N up to 512).
    localparam int COUNT_W = 10;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccum  = 2'd1,
        StFinish = 2'd2,
        StOutput = 2'd3
    } state_e;

endpackage

// File: rtl/phase_wrap_3600.sv
// Folds a phase sum in (-5400, 5400) into the half-open circle (-1800, 1800].
module phase_wrap_3600
    import phase_window_stats_pkg::*;
#(
    parameter int IN_W = WRAP_W
) (
    input  logic signed [IN_W-1:0]    raw,
    output logic signed [PHASE_W-1:0] wrapped
);

    localparam logic signed [IN_W-1:0] HALF = IN_W'(PHASE_HALF);
    localparam logic signed [IN_W-1:0] FULL = IN_W'(PHASE_FULL);

    logic signed [IN_W-1:0] adj;

    // One fold suffices: every caller adds two in-range phases.
    always_comb begin
        adj = raw;
        if (raw > HALF) begin
            adj = raw - FULL;
        end else if (raw <= -HALF) begin
            adj = raw + FULL;
        end
    end

    assign wrapped = PHASE_W'(adj);

endmodule

// File: rtl/phase_window_stats.sv
// Windowed circular statistics (mean, min, max, peak-to-peak) of a phase stream.
// Deltas are taken against the first sample of each window, so the statistics
// stay correct across the +/-180 degree seam.
module phase_window_stats
    import phase_window_stats_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [15:0]       phase_diff,
    input  logic                     phase_valid,
    input  logic [7:0]               phase_confidence,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [7:0]               conf_threshold,
    input  logic [2:0]               win_log2,
    output logic signed [15:0]       mean_phase,
    output logic signed [15:0]       min_phase,
    output logic signed [15:0]       max_phase,
    output logic [11:0]              pp_phase,
    output logic                     stats_valid,
    output logic [CNT_W-1:0]         reject_cnt,
    output logic [CNT_W-1:0]         overrun_cnt,
    output logic                     busy
);

    localparam logic signed [PHASE_W-1:0] HALF_P  = PHASE_W'(PHASE_HALF);
    localparam logic [CNT_W-1:0]          CNT_MAX = '1;

    state_e state_q, state_d;

    // Window accumulation state
    logic signed [PHASE_W-1:0] ref_q;
    logic signed [PHASE_W-1:0] dmin_q;
    logic signed [PHASE_W-1:0] dmax_q;
    logic signed [ACC_W-1:0]   sum_q;
    logic [COUNT_W-1:0]        count_q;
    logic [3:0]                log2n_q;

    // Results computed in FINISH, published in OUTPUT
    logic signed [PHASE_W-1:0] res_mean_q;
    logic signed [PHASE_W-1:0] res_min_q;
    logic signed [PHASE_W-1:0] res_max_q;
    logic [11:0]               res_pp_q;

    logic conf_ok, range_ok, sample_req, sample_ok, reject, overrun, last;
    logic [COUNT_W-1:0] n_len;

    assign range_ok   = (phase_diff >= -HALF_P) && (phase_diff <= HALF_P);
    assign conf_ok    = phase_confidence >= conf_threshold;
    // clear discards any coincident sample without counting it
    assign sample_req = phase_valid && enable && !clear;
    assign sample_ok  = sample_req && conf_ok && range_ok;
    assign reject     = sample_req && !(conf_ok && range_ok);
    assign overrun    = sample_ok && ((state_q == StFinish) || (state_q == StOutput));
    assign n_len      = COUNT_W'(1) << log2n_q;
    assign last       = (count_q + COUNT_W'(1)) == n_len;
    assign busy       = (state_q != StIdle);

    // Delta of the incoming sample against the window reference
    logic signed [WRAP_W-1:0]  delta_raw;
    logic signed [PHASE_W-1:0] delta;

    assign delta_raw = WRAP_W'(phase_diff) - WRAP_W'(ref_q);

    phase_wrap_3600 #(.IN_W(WRAP_W)) u_wrap_delta (
        .raw     (delta_raw),
        .wrapped (delta)
    );

    // Rounded mean delta: (sum + N/2) >>> log2(N)
    logic signed [ACC_W-1:0]   half_n, rounded, m_full;
    logic signed [WRAP_W-1:0]  mean_raw, min_raw, max_raw;
    logic signed [PHASE_W-1:0] mean_w, min_w, max_w;
    logic [PHASE_W-1:0]        pp_full;

    assign half_n   = ACC_W'(n_len >> 1);
    assign rounded  = sum_q + half_n;
    assign m_full   = rounded >>> log2n_q;
    assign mean_raw = WRAP_W'(ref_q) + WRAP_W'(m_full);
    assign min_raw  = WRAP_W'(ref_q) + WRAP_W'(dmin_q);
    assign max_raw  = WRAP_W'(ref_q) + WRAP_W'(dmax_q);
    assign pp_full  = dmax_q - dmin_q;

    phase_wrap_3600 #(.IN_W(WRAP_W)) u_wrap_mean (
        .raw     (mean_raw),
        .wrapped (mean_w)
    );

    phase_wrap_3600 #(.IN_W(WRAP_W)) u_wrap_min (
        .raw     (min_raw),
        .wrapped (min_w)
    );

    phase_wrap_3600 #(.IN_W(WRAP_W)) u_wrap_max (
        .raw     (max_raw),
        .wrapped (max_w)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear and enable loss abort back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (sample_ok) state_d = StAccum;
            StAccum: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (sample_ok && last) begin
                    state_d = StFinish;
                end
            end
            StFinish: state_d = StOutput;
            StOutput: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
        if (clear) state_d = StIdle;
    end

    // Window accumulation and result staging
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q      <= '0;
            dmin_q     <= '0;
            dmax_q     <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            log2n_q    <= '0;
            res_mean_q <= '0;
            res_min_q  <= '0;
            res_max_q  <= '0;
            res_pp_q   <= '0;
        end else if (clear) begin
            ref_q      <= '0;
            dmin_q     <= '0;
            dmax_q     <= '0;
            sum_q      <= '0;
            count_q    <= '0;
            log2n_q    <= '0;
            res_mean_q <= '0;
            res_min_q  <= '0;
            res_max_q  <= '0;
            res_pp_q   <= '0;
        end else begin
            if ((state_q == StIdle) && sample_ok) begin
                ref_q   <= phase_diff;
                log2n_q <= {1'b0, win_log2} + 4'd2;
                sum_q   <= '0;
                dmin_q  <= '0;
                dmax_q  <= '0;
                count_q <= COUNT_W'(1);
            end else if ((state_q == StAccum) && sample_ok) begin
                sum_q <= sum_q + ACC_W'(delta);
                if (delta < dmin_q) dmin_q <= delta;
                if (delta > dmax_q) dmax_q <= delta;
                count_q <= count_q + COUNT_W'(1);
            end
            if (state_q == StFinish) begin
                res_mean_q <= mean_w;
                res_min_q  <= min_w;
                res_max_q  <= max_w;
                res_pp_q   <= 12'(pp_full);
            end
        end
    end

    // Published statistics and saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mean_phase  <= '0;
            min_phase   <= '0;
            max_phase   <= '0;
            pp_phase    <= '0;
            stats_valid <= 1'b0;
            reject_cnt  <= '0;
            overrun_cnt <= '0;
        end else if (clear) begin
            mean_phase  <= '0;
            min_phase   <= '0;
            max_phase   <= '0;
            pp_phase    <= '0;
            stats_valid <= 1'b0;
            reject_cnt  <= '0;
            overrun_cnt <= '0;
        end else begin
            stats_valid <= 1'b0;
            if (state_q == StOutput) begin
                mean_phase  <= res_mean_q;
                min_phase   <= res_min_q;
                max_phase   <= res_max_q;
                pp_phase    <= res_pp_q;
                stats_valid <= 1'b1;
            end
            if (reject && (reject_cnt != CNT_MAX)) begin
                reject_cnt <= reject_cnt + CNT_W'(1);
            end
            if (overrun && (overrun_cnt != CNT_MAX)) begin
                overrun_cnt <= overrun_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_phase_window_stats.sv
// Self-checking bench for phase_window_stats: directed scenarios plus random
// windows checked against a list-based model of the window statistics.
module tb_phase_window_stats;

    localparam int ACC_W = 24;
    localparam int CNT_W = 8;
    localparam int CMAX  = 255;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] phase_diff = '0;
    logic               phase_valid = 1'b0;
    logic [7:0]         phase_confidence = '0;
    logic               enable = 1'b1;
    logic               clear = 1'b0;
    logic [7:0]         conf_threshold = 8'd128;
    logic [2:0]         win_log2 = 3'd0;
    logic signed [15:0] mean_phase, min_phase, max_phase;
    logic [11:0]        pp_phase;
    logic               stats_valid;
    logic [CNT_W-1:0]   reject_cnt, overrun_cnt;
    logic               busy;

    phase_window_stats #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phase_diff       (phase_diff),
        .phase_valid      (phase_valid),
        .phase_confidence (phase_confidence),
        .enable           (enable),
        .clear            (clear),
        .conf_threshold   (conf_threshold),
        .win_log2         (win_log2),
        .mean_phase       (mean_phase),
        .min_phase        (min_phase),
        .max_phase        (max_phase),
        .pp_phase         (pp_phase),
        .stats_valid      (stats_valid),
        .reject_cnt       (reject_cnt),
        .overrun_cnt      (overrun_cnt),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int exp_reject = 0, exp_overrun = 0;
    int exp_mean = 0, exp_min = 0, exp_max = 0, exp_pp = 0;
    int win[$];

    function automatic int wrap_ph(int v);
        int r;
        r = v;
        while (r > 1800) r -= 3600;
        while (r <= -1800) r += 3600;
        return r;
    endfunction

    // Statistics of the accepted samples in win[], straight from the definitions.
    function automatic void model_window();
        int r, sum, dmin, dmax, d, n, num, q;
        r = win[0]; sum = 0; dmin = 0; dmax = 0; n = win.size();
        foreach (win[i]) begin
            d = wrap_ph(win[i] - r);
            sum += d;
            if (d < dmin) dmin = d;
            if (d > dmax) dmax = d;
        end
        num = sum + n / 2;
        q = num / n;
        if ((num % n != 0) && (num < 0)) q -= 1;
        exp_mean = wrap_ph(r + q);
        exp_min  = wrap_ph(r + dmin);
        exp_max  = wrap_ph(r + dmax);
        exp_pp   = dmax - dmin;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int p, input int c);
        phase_diff       = 16'(p);
        phase_confidence = 8'(c);
        phase_valid      = 1'b1;
        @(negedge clk);
        phase_valid = 1'b0;
    endtask

    // Sample offered in IDLE/ACCUM with enable high; model decides its fate.
    task automatic offer(input int p, input int c);
        if ((c >= int'(conf_threshold)) && (p >= -1800) && (p <= 1800)) begin
            win.push_back(p);
        end else if (exp_reject < CMAX) begin
            exp_reject++;
        end
        sample(p, c);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/mean"}, mean_phase, exp_mean);
        check({tag, "/min"}, min_phase, exp_min);
        check({tag, "/max"}, max_phase, exp_max);
        check({tag, "/pp"}, pp_phase, exp_pp);
        check({tag, "/rej"}, reject_cnt, exp_reject);
        check({tag, "/ovr"}, overrun_cnt, exp_overrun);
    endtask

    // Called on the negedge right after the edge that accepted the Nth sample.
    task automatic expect_stats(input string tag);
        model_window();
        check({tag, "/sv_c0"}, stats_valid, 0);
        check({tag, "/busy"}, busy, 1);
        @(negedge clk);
        check({tag, "/sv_c1"}, stats_valid, 0);
        @(negedge clk);
        check({tag, "/sv_c2"}, stats_valid, 1);
        check_outputs(tag);
        @(negedge clk);
        check({tag, "/sv_c3"}, stats_valid, 0);
        check({tag, "/idle"}, busy, 0);
        check({tag, "/hold"}, mean_phase, exp_mean);
        win.delete();
    endtask

    task automatic zero_model();
        exp_reject = 0; exp_overrun = 0;
        exp_mean = 0; exp_min = 0; exp_max = 0; exp_pp = 0;
        win.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wl, n, p, c;
        // Reset state
        #12;
        check("reset", {mean_phase, min_phase}, 0);
        check("reset/max", max_phase, 0);
        check("reset/pp", pp_phase, 0);
        check("reset/sv", stats_valid, 0);
        check("reset/rej", reject_cnt, 0);
        check("reset/ovr", overrun_cnt, 0);
        check("reset/busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        // Basic window
        win_log2 = 3'd0; conf_threshold = 8'd128;
        offer(100, 255); offer(102, 255); offer(98, 255); offer(100, 255);
        expect_stats("basic");
        check("basic/mean_k", mean_phase, 100);
        check("basic/pp_k", pp_phase, 4);

        // Across the seam
        offer(1790, 255); offer(-1790, 255); offer(1780, 255); offer(-1780, 255);
        expect_stats("seam");
        check("seam/mean_k", mean_phase, 1800);
        check("seam/max_k", max_phase, -1780);
        check("seam/pp_k", pp_phase, 40);

        // Confidence rejects do not advance the window
        conf_threshold = 8'd200;
        repeat (3) offer(-600, 100);
        repeat (4) offer(-600, 255);
        expect_stats("conf");
        check("conf/rej_k", reject_cnt, 3);
        check("conf/mean_k", mean_phase, -600);

        // Rounding of a negative sum, range boundaries
        conf_threshold = 8'd128;
        offer(-6, 255); offer(0, 255); offer(0, 255); offer(0, 255);
        expect_stats("round");
        check("round/mean_k", mean_phase, -1);
        offer(1801, 255);
        check("range/1801", reject_cnt, exp_reject);
        offer(-1801, 255);
        check("range/-1801", reject_cnt, exp_reject);
        offer(-1800, 255); offer(1800, 255); offer(0, 255); offer(900, 255);
        expect_stats("edges");

        // clear mid-window, coincident sample discarded
        offer(500, 255); offer(510, 255);
        phase_diff = 16'sd520; phase_confidence = 8'd255; phase_valid = 1'b1; clear = 1'b1;
        @(negedge clk);
        phase_valid = 1'b0; clear = 1'b0;
        zero_model();
        check_outputs("clear");
        check("clear/busy", busy, 0);
        repeat (4) begin
            @(negedge clk);
            check("clear/no_sv", stats_valid, 0);
        end
        offer(-200, 255); offer(-210, 255); offer(-190, 255); offer(-200, 255);
        expect_stats("fresh");

        // Overrun: acceptable sample while in FINISH
        offer(10, 255); offer(20, 255); offer(30, 255); offer(40, 255);
        model_window();
        sample(50, 255);
        exp_overrun = 1;
        check("ovr/sv_c1", stats_valid, 0);
        @(negedge clk);
        check("ovr/sv_c2", stats_valid, 1);
        check_outputs("ovr");
        win.delete();
        @(negedge clk);

        // enable low aborts the window; stats hold
        offer(700, 255); offer(710, 255);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        win.delete();
        check("abort/busy", busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("abort/no_sv", stats_valid, 0);
        end
        check_outputs("abort");

        // Reject counter saturation
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        zero_model();
        repeat (260) offer(0, 0);
        check("sat/rej", reject_cnt, CMAX);
        clear = 1'b1; @(negedge clk); clear = 1'b0;
        zero_model();
        check("sat/cleared", reject_cnt, 0);

        // Random windows; win_log2 scrambled after the first accepted sample
        for (int w = 0; w < 8; w++) begin
            wl = int'($urandom_range(0, 3));
            n = 1 << (wl + 2);
            win_log2 = 3'(wl);
            conf_threshold = 8'($urandom_range(40, 200));
            for (int k = 0; k < 2000 && win.size() < n; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    @(negedge clk);
                end else begin
                    if ($urandom_range(0, 9) == 0) begin
                        p = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1801, 1900))
                                                        : -int'($urandom_range(1801, 1900));
                    end else begin
                        p = int'($urandom_range(0, 3600)) - 1800;
                    end
                    c = int'($urandom_range(0, 255));
                    offer(p, c);
                    if (win.size() == 1) win_log2 = 3'($urandom);
                end
            end
            expect_stats($sformatf("rand%0d", w));
        end

        // Asynchronous reset mid-window
        win_log2 = 3'd0; conf_threshold = 8'd128;
        offer(300, 255); offer(310, 255);
        #2 rst_n = 1'b0;
        #1;
        zero_model();
        check_outputs("arst");
        check("arst/sv", stats_valid, 0);
        check("arst/busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("arst/no_sv", stats_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/phase_window_stats.md
PHASE_WINDOW_STATS -- requirements
Module: phase_window_stats

Interface
REQ-001 Parameter: ACC_W, 24, signed accumulator width for unwrapped deltas; must be at least 21.
REQ-002 Parameter: CNT_W, 8, width of the saturating reject/overrun counters.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 phase_diff  in  16 signed  phase difference, 0.1° units; legal range -1800..1800.
REQ-006 phase_valid  in  1  one-cycle strobe qualifying phase_diff and phase_confidence.
REQ-007 phase_confidence  in  8  quality of the current sample; 255 is best.
REQ-008 enable  in  1  block enable.
REQ-009 clear  in  1  synchronous pulse that aborts the current window.
REQ-010 conf_threshold  in  8  minimum confidence for a sample to be accepted.
REQ-011 win_log2  in  3  window length N = 2^(win_log2+2), giving 4..512 samples.
REQ-012 mean_phase  out  16 signed  circular mean of the window, 0.1° units, range (-1800,1800].
REQ-013 min_phase / max_phase  out  16 signed each  window extremes, wrapped to (-1800,1800].
REQ-014 pp_phase  out  12  peak-to-peak spread of the window, 0..3599.
REQ-015 stats_valid  out  1  one-cycle strobe when the stats outputs update.
REQ-016 reject_cnt  out  CNT_W  saturating count of rejected samples.
REQ-017 overrun_cnt  out  CNT_W  saturating count of dropped samples.
REQ-018 busy  out  1  high while the state is not IDLE.

Function
REQ-019 A sample is accepted when phase_valid=1, enable=1, phase_confidence >= conf_threshold, and |phase_diff| <= 1800.
- A sample with phase_valid=1 and enable=1 that fails any other test increments reject_cnt.
- Rejected samples do not advance the window.
REQ-020 The FSM has four states: IDLE, ACCUM, FINISH, OUTPUT.
- IDLE -> ACCUM on the first accepted sample.
- ACCUM -> FINISH on the Nth accepted sample.
- FINISH -> OUTPUT after 1 cycle.
- OUTPUT -> IDLE after 1 cycle.
REQ-021 On the first accepted sample of a window:
- latch it as the reference r;
- latch N from win_log2; win_log2 changes mid-window are ignored;
- set sum=0, dmin=0, dmax=0, count=1.
REQ-022 For each accepted sample p:
- d = p - r, wrapped: if d > 1800 then d -= 3600; if d <= -1800 then d += 3600;
- sum += d; update dmin and dmax; count += 1.
REQ-023 FINISH computes the results:
- m = (sum + N/2) >>> log2(N), arithmetic shift (round half up);
- mean_phase = wrap(r+m); min_phase = wrap(r+dmin); max_phase = wrap(r+dmax); pp_phase = dmax - dmin;
- wrap() maps into (-1800,1800].
REQ-024 In OUTPUT, the stats outputs are registered and stats_valid=1 for exactly one cycle.
- Latency: stats_valid asserts 2 cycles after the edge that accepts the Nth sample.
REQ-025 Stats outputs hold their values until the next stats_valid, a clear, or a reset.
REQ-026 A sample that would be accepted but arrives in FINISH or OUTPUT is dropped and increments overrun_cnt.
REQ-027 clear=1 forces IDLE, discards partial sums, and zeroes all outputs and counters.
- clear wins over a simultaneous phase_valid; that sample is discarded and not counted.
REQ-028 enable=0 in ACCUM aborts the window back to IDLE; the stats outputs hold their values.
REQ-029 reject_cnt and overrun_cnt saturate at 2^CNT_W-1; they never wrap.

Reset
REQ-030 rst_n=0 immediately forces:
- state IDLE;
- all outputs 0: mean/min/max/pp = 0, stats_valid = 0, counters = 0, busy = 0;
- internal r, sum, dmin, dmax, count = 0.
REQ-031 Reset asserted mid-window discards the window; no stats_valid is produced for it.

Structure
REQ-032 A shared phase package holds:
- PHASE_HALF=1800 and PHASE_FULL=3600;
- the phase word width (16);
- the FSM state encoding.
REQ-033 One combinational sub-module, phase_wrap_3600, implements wrap() and is instantiated for the delta and for all three results.

Verification
REQ-034 win_log2=0, thr=128, conf=255, samples 100,102,98,100 -> mean 100, min 98, max 102, pp 4; stats_valid 2 cycles after the 4th sample.
REQ-035 win_log2=0, samples 1790,-1790,1780,-1780 -> deltas 0,20,-10,30; mean 1800, min 1780, max -1780, pp 40.
REQ-036 thr=200, 3 samples at conf=100 then 4 at conf=255 of value -600 -> reject_cnt=3; mean -600, pp 0.
REQ-037 Boundary inputs:
- samples -6 ,0,0,0 (win_log2=0) -> sum -6, mean -1 (rounding check);
- a sample of 1801 -> rejected, reject_cnt increments.
REQ-038 clear after 2 accepted samples -> no stats_valid; the next 4 samples form a fresh window.
- A sample during FINISH -> overrun_cnt=1.
REQ-039 rst_n pulled low mid-window -> all outputs 0 asynchronously; no stats_valid after release.
